regfile_block_mover: RTL and testbench
======================================

REGFILE_BLOCK_MOVER -- requirements
Module: regfile_block_mover

Interface
REQ-001 The block SHALL have one clock, Clk; reset is synchronous and active-high, named Reset; all state updates occur on posedge Clk.
REQ-002 Clk  input  1  system clock; the register file it drives writes on negedge Clk.
REQ-003 Reset  input  1  synchronous active-high reset.
REQ-004 CmdValid  input  1  command offered; accepted when CmdValid && CmdReady at posedge.
REQ-005 CmdReady  output  1  high only in IDLE.
REQ-006 CmdOp  input  2  operation: 0 COPY, 1 FILL, 2 SUM, 3 reserved.
REQ-007 CmdSrc  input  5  source base register index.
REQ-008 CmdDst  input  5  destination base register index.
REQ-009 CmdCount  input  6  element count; 0 = no-op; values 33-63 are clamped to 32.
REQ-010 CmdImm  input  64  fill value for FILL.
REQ-011 RA, RB  output  5  register file read addresses; RB SHALL always equal RA.
REQ-012 BusA  input  64  register file read data for RA, valid by the posedge following an RA change.
REQ-013 BusB  input  64  unused; sampled by nothing.
REQ-014 RW  output  5  register file write address.
REQ-015 BusW  output  64  register file write data.
REQ-016 RegWr  output  1  register file write enable; registered, high for exactly one cycle per performed write.
REQ-017 Done  output  1  one-cycle pulse at command completion.
REQ-018 Result  output  64  COPY: last value read; FILL: CmdImm; SUM: wrapping sum; reserved or count 0: 0; held until the next Done.
REQ-019 SkipCount  output  6  number of suppressed writes to register 31 in the last command; held until the next Done.
REQ-020 CmdErr  output  1  high together with Done for a reserved opcode, otherwise low.

Function
REQ-021 The FSM SHALL have the states IDLE, RD, WR, ACC and DONE.
REQ-022 On acceptance, the block SHALL latch the operands, set element index i=0, clear the accumulator and skip counter, and go to RD for COPY/SUM, WR for FILL, or DONE for count 0 or a reserved opcode.
REQ-023 RD: RA=(src+i) mod 32 (5-bit wrap), RegWr=0; next state WR for COPY, ACC for SUM.
REQ-024 WR (COPY): capture BusA and drive RW=(dst+i) mod 32 and BusW=captured value; FILL: BusW=CmdImm; RegWr=1 unless RW==31.
REQ-025 Write to index 31 SHALL be suppressed (RegWr=0, BusW/RW still driven) and SkipCount incremented.
REQ-026 ACC: accumulator += BusA, 64-bit, carry discarded; register 31 is read like any other index.
REQ-027 After WR/ACC: if i==count-1 go to DONE, else i+1 and go to RD (COPY/SUM) or stay in WR (FILL).
REQ-028 Throughput: COPY and SUM take 2 cycles per element; FILL 1 cycle per element; acceptance to Done = 2N+1 (COPY/SUM) or N+1 (FILL) cycles; count 0 gives Done the cycle after acceptance.
REQ-029 Elements SHALL be processed in ascending i only; overlapping COPY with dst>src propagates already-written values, and this is defined behaviour.
REQ-030 DONE: Done=1 for one cycle, Result/SkipCount/CmdErr update, then IDLE; CmdReady=0 in DONE.
REQ-031 CmdValid outside IDLE SHALL be ignored; commands are never queued.
REQ-032 RegWr SHALL be 0 in IDLE, RD, ACC and DONE.

Reset
REQ-033 Reset SHALL force IDLE, CmdReady=1, RegWr=0, Done=0, CmdErr=0, RA=RB=RW=0, BusW=0, Result=0 and SkipCount=0 at the next posedge.
REQ-034 Reset mid-command SHALL abort the command with no further writes and no Done pulse; writes already performed SHALL remain.
REQ-035 Reset SHALL take priority over command acceptance in the same cycle.

Verification
REQ-036 FILL src=x, dst=4, count=3, Imm=0xDEAD -> r4..r6=0xDEAD, 3 RegWr pulses, Done 4 cycles after acceptance, Result=0xDEAD, SkipCount=0.
REQ-037 COPY src=1, dst=29, count=4, with r1..r4=10,20,30,40 -> r29=10, r30=20, r31 unchanged (write suppressed), r0=40, SkipCount=1, Result=40, Done 9 cycles after acceptance.
REQ-038 SUM src=30, count=3, with r30=0xFFFF_FFFF_FFFF_FFFF, r31=0, r0=2 -> Result=1 (wrap), no RegWr, Done 7 cycles after acceptance.
REQ-039 Count=0 and CmdOp=3 -> Done the next cycle, Result=0, CmdErr=1 only for op 3, no RegWr.
REQ-040 FILL count=8 with Reset asserted during the 3rd WR cycle -> exactly 2 writes performed, no Done, CmdReady=1 the cycle after reset; CmdValid held high during a busy command -> the command is not accepted until IDLE.

Source files
------------

// File: rtl/regfile_block_mover.sv
// Block mover for a 32 x 64-bit register file: COPY, FILL and SUM over a run of
// consecutive registers. The file's write port on index 31 is never driven.
module regfile_block_mover (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic [1:0]  CmdOp,
  input  logic [4:0]  CmdSrc,
  input  logic [4:0]  CmdDst,
  input  logic [5:0]  CmdCount,
  input  logic [63:0] CmdImm,
  output logic [4:0]  RA,
  output logic [4:0]  RB,
  input  logic [63:0] BusA,
  input  logic [63:0] BusB,
  output logic [4:0]  RW,
  output logic [63:0] BusW,
  output logic        RegWr,
  output logic        Done,
  output logic [63:0] Result,
  output logic [5:0]  SkipCount,
  output logic        CmdErr
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_ACC  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] OP_COPY = 2'd0;
  localparam logic [1:0] OP_FILL = 2'd1;
  localparam logic [1:0] OP_RSVD = 2'd3;

  logic [2:0]  state;
  logic [1:0]  op_q;
  logic [4:0]  src_q;
  logic [4:0]  dst_q;
  logic [5:0]  cnt_q;
  logic [63:0] imm_q;
  logic [4:0]  idx;
  logic [63:0] acc;
  logic [5:0]  skip;

  logic        last_elem;
  logic [4:0]  idx_next;
  logic [4:0]  copy_addr;
  logic [4:0]  fill_addr;
  logic [4:0]  src_next;
  logic [63:0] acc_sum;

  // Read port B mirrors A; its data bus is deliberately left unconsumed.
  logic unused_bus_b;
  assign unused_bus_b = ^BusB;

  assign CmdReady  = (state == S_IDLE);
  assign RB        = RA;
  assign idx_next  = idx + 5'd1;
  assign last_elem = ({1'b0, idx} == cnt_q - 6'd1);
  assign copy_addr = dst_q + idx;
  assign fill_addr = dst_q + idx_next;
  assign src_next  = src_q + idx_next;
  assign acc_sum   = acc + BusA;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      op_q      <= OP_COPY;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      imm_q     <= '0;
      idx       <= '0;
      acc       <= '0;
      skip      <= '0;
      RA        <= '0;
      RW        <= '0;
      BusW      <= '0;
      RegWr     <= 1'b0;
      Done      <= 1'b0;
      Result    <= '0;
      SkipCount <= '0;
      CmdErr    <= 1'b0;
    end else begin
      // NOTE: strobes default low here so each is a one-cycle pulse; every
      // assignment in this block is non-blocking, so later ones win without ordering hazards.
      RegWr  <= 1'b0;
      Done   <= 1'b0;
      CmdErr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (CmdValid) begin
            op_q  <= CmdOp;
            src_q <= CmdSrc;
            dst_q <= CmdDst;
            imm_q <= CmdImm;
            cnt_q <= (CmdCount > 6'd32) ? 6'd32 : CmdCount;
            idx   <= '0;
            acc   <= '0;
            skip  <= '0;
            if (CmdCount == 6'd0 || CmdOp == OP_RSVD) begin
              state     <= S_DONE;
              Done      <= 1'b1;
              Result    <= '0;
              SkipCount <= '0;
              CmdErr    <= (CmdOp == OP_RSVD);
            end else if (CmdOp == OP_FILL) begin
              state <= S_WR;
              RW    <= CmdDst;
              BusW  <= CmdImm;
              RegWr <= (CmdDst != 5'd31);
              skip  <= {5'd0, CmdDst == 5'd31};
            end else begin
              state <= S_RD;
              RA    <= CmdSrc;
            end
          end
        end
        S_RD: begin
          if (op_q == OP_COPY) begin
            state <= S_WR;
            RW    <= copy_addr;
            BusW  <= BusA;
            RegWr <= (copy_addr != 5'd31);
            skip  <= skip + {5'd0, copy_addr == 5'd31};
          end else begin
            state <= S_ACC;
          end
        end
        S_WR: begin
          if (last_elem) begin
            state     <= S_DONE;
            Done      <= 1'b1;
            Result    <= (op_q == OP_FILL) ? imm_q : BusW;
            SkipCount <= skip;
          end else begin
            idx <= idx_next;
            if (op_q == OP_FILL) begin
              RW    <= fill_addr;
              RegWr <= (fill_addr != 5'd31);
              skip  <= skip + {5'd0, fill_addr == 5'd31};
            end else begin
              state <= S_RD;
              RA    <= src_next;
            end
          end
        end
        S_ACC: begin
          acc <= acc_sum;
          if (last_elem) begin
            state     <= S_DONE;
            Done      <= 1'b1;
            Result    <= acc_sum;
            SkipCount <= skip;
          end else begin
            idx   <= idx_next;
            state <= S_RD;
            RA    <= src_next;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_block_mover.sv
// Self-checking bench for regfile_block_mover: a negedge-write register file
// model, directed scenarios, and randomized commands against a sequential reference.
module tb_regfile_block_mover;

  logic        Clk;
  logic        Reset;
  logic        CmdValid;
  logic        CmdReady;
  logic [1:0]  CmdOp;
  logic [4:0]  CmdSrc;
  logic [4:0]  CmdDst;
  logic [5:0]  CmdCount;
  logic [63:0] CmdImm;
  logic [4:0]  RA;
  logic [4:0]  RB;
  logic [63:0] BusA;
  logic [63:0] BusB;
  logic [4:0]  RW;
  logic [63:0] BusW;
  logic        RegWr;
  logic        Done;
  logic [63:0] Result;
  logic [5:0]  SkipCount;
  logic        CmdErr;

  regfile_block_mover dut (
    .Clk(Clk), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdOp(CmdOp), .CmdSrc(CmdSrc), .CmdDst(CmdDst), .CmdCount(CmdCount),
    .CmdImm(CmdImm), .RA(RA), .RB(RB), .BusA(BusA), .BusB(BusB), .RW(RW),
    .BusW(BusW), .RegWr(RegWr), .Done(Done), .Result(Result),
    .SkipCount(SkipCount), .CmdErr(CmdErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Register file environment: writes on negedge, combinational reads.
  logic [63:0] rf [32];
  logic [63:0] pl_vals [32];
  logic        pl_all = 1'b0;
  int          n_writes = 0;

  always @(negedge Clk) begin
    if (pl_all) begin
      for (int k = 0; k < 32; k++) rf[k] <= pl_vals[k];
    end else if (RegWr) begin
      rf[RW]   <= BusW;
      n_writes <= n_writes + 1;
    end
  end

  assign BusA = rf[RA];
  assign BusB = rf[RB];

  // Reference state and per-command expectations.
  logic [63:0] mrf [32];
  logic [63:0] exp_rf [32];
  logic [63:0] exp_result;
  int          exp_skip;
  int          exp_err;
  int          exp_lat;
  int          exp_writes;
  int          wr_base;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_preload();
    mrf    = pl_vals;
    pl_all = 1'b1;
    @(negedge Clk);
    #1;
    pl_all = 1'b0;
    tick();
  endtask

  task automatic randomize_preload();
    for (int k = 0; k < 32; k++) pl_vals[k] = {$urandom, $urandom};
  endtask

  // Elements are handled strictly in ascending order against the evolving array,
  // which also gives the defined result for overlapping copies.
  task automatic model_cmd(input logic [1:0] op, input logic [4:0] src,
                           input logic [4:0] dst, input logic [5:0] cnt,
                           input logic [63:0] imm);
    int n;
    logic [63:0] acc;
    exp_rf     = mrf;
    n          = (int'(cnt) > 32) ? 32 : int'(cnt);
    exp_result = '0;
    exp_skip   = 0;
    exp_writes = 0;
    exp_err    = (op == 2'd3) ? 1 : 0;
    acc        = '0;
    if (op == 2'd3 || n == 0) begin
      exp_lat = 1;
    end else begin
      exp_lat = (op == 2'd1) ? n + 1 : 2 * n + 1;
      for (int i = 0; i < n; i++) begin
        int s;
        int d;
        s = (int'(src) + i) % 32;
        d = (int'(dst) + i) % 32;
        if (op == 2'd2) begin
          acc        = acc + exp_rf[s];
          exp_result = acc;
        end else begin
          exp_result = (op == 2'd0) ? exp_rf[s] : imm;
          if (d == 31) exp_skip++;
          else begin
            exp_rf[d] = exp_result;
            exp_writes++;
          end
        end
      end
    end
  endtask

  task automatic start_cmd(input logic [1:0] op, input logic [4:0] src,
                           input logic [4:0] dst, input logic [5:0] cnt,
                           input logic [63:0] imm, input bit keep_valid);
    model_cmd(op, src, dst, cnt, imm);
    for (int k = 0; k < 100 && CmdReady !== 1'b1; k++) tick();
    check("ready_before_cmd", CmdReady, 1);
    CmdOp    = op;
    CmdSrc   = src;
    CmdDst   = dst;
    CmdCount = cnt;
    CmdImm   = imm;
    CmdValid = 1'b1;
    wr_base  = n_writes;
    tick();
    if (!keep_valid) CmdValid = 1'b0;
  endtask

  task automatic finish_cmd(input string tag);
    int cycles;
    cycles = 1;
    while (Done !== 1'b1 && cycles < 150) begin
      tick();
      cycles++;
    end
    check({tag, "_done_seen"}, Done, 1);
    check({tag, "_latency"}, cycles, exp_lat);
    check({tag, "_result"}, Result, exp_result);
    check({tag, "_skip"}, SkipCount, exp_skip);
    check({tag, "_err"}, CmdErr, exp_err);
    check({tag, "_writes"}, n_writes - wr_base, exp_writes);
    check({tag, "_regwr_in_done"}, RegWr, 0);
    check({tag, "_ready_in_done"}, CmdReady, 0);
    for (int k = 0; k < 32; k++)
      check($sformatf("%s_rf%0d", tag, k), rf[k], exp_rf[k]);
    mrf = exp_rf;
    tick();
    check({tag, "_done_pulse_end"}, Done, 0);
    check({tag, "_err_pulse_end"}, CmdErr, 0);
    check({tag, "_ready_after"}, CmdReady, 1);
    check({tag, "_result_held"}, Result, exp_result);
    check({tag, "_skip_held"}, SkipCount, exp_skip);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, CmdReady, 1);
    check({tag, "_regwr"}, RegWr, 0);
    check({tag, "_done"}, Done, 0);
    check({tag, "_err"}, CmdErr, 0);
    check({tag, "_ra"}, RA, 0);
    check({tag, "_rb"}, RB, 0);
    check({tag, "_rw"}, RW, 0);
    check({tag, "_busw"}, BusW, 0);
    check({tag, "_result"}, Result, 0);
    check({tag, "_skip"}, SkipCount, 0);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [5:0]  r_cnt;
    logic [63:0] saved22;
    bit          saw_done;
    int          base;

    Reset    = 1'b1;
    CmdValid = 1'b0;
    CmdOp    = '0;
    CmdSrc   = '0;
    CmdDst   = '0;
    CmdCount = '0;
    CmdImm   = '0;
    randomize_preload();
    apply_preload();
    tick();
    check_reset_values("reset");
    Reset = 1'b0;
    tick();

    // FILL r4..r6 with 0xDEAD.
    start_cmd(2'd1, 5'd9, 5'd4, 6'd3, 64'hDEAD, 1'b0);
    finish_cmd("fill3");
    check("fill3_r5", rf[5], 64'hDEAD);

    // COPY across the top of the file; the write to r31 is suppressed.
    randomize_preload();
    pl_vals[1] = 64'd10;
    pl_vals[2] = 64'd20;
    pl_vals[3] = 64'd30;
    pl_vals[4] = 64'd40;
    apply_preload();
    start_cmd(2'd0, 5'd1, 5'd29, 6'd4, 64'h0, 1'b0);
    finish_cmd("copy_wrap");
    check("copy_wrap_r29", rf[29], 64'd10);
    check("copy_wrap_r0", rf[0], 64'd40);
    check("copy_wrap_r31_kept", rf[31], pl_vals[31]);

    // SUM with 64-bit wrap, reading r31.
    pl_vals     = mrf;
    pl_vals[30] = 64'hFFFF_FFFF_FFFF_FFFF;
    pl_vals[31] = 64'd0;
    pl_vals[0]  = 64'd2;
    apply_preload();
    start_cmd(2'd2, 5'd30, 5'd7, 6'd3, 64'h0, 1'b0);
    finish_cmd("sum_wrap");
    check("sum_wrap_value", Result, 64'd1);

    // Count zero and reserved opcode.
    start_cmd(2'd0, 5'd3, 5'd8, 6'd0, 64'h0, 1'b0);
    finish_cmd("count0");
    start_cmd(2'd3, 5'd3, 5'd8, 6'd5, 64'h1234, 1'b0);
    finish_cmd("reserved");

    // Overlapping COPY propagates r5 upward; clamped FILL covers the whole file.
    start_cmd(2'd0, 5'd5, 5'd6, 6'd4, 64'h0, 1'b0);
    finish_cmd("copy_overlap");
    start_cmd(2'd1, 5'd0, 5'd0, 6'd50, 64'h5A5A, 1'b0);
    finish_cmd("fill_clamp");
    randomize_preload();
    apply_preload();

    // CmdValid held through a busy command: the second is taken only from IDLE.
    start_cmd(2'd1, 5'd0, 5'd8, 6'd2, 64'hAAAA, 1'b1);
    CmdDst   = 5'd12;
    CmdImm   = 64'hBBBB;
    finish_cmd("held_a");
    start_cmd(2'd1, 5'd0, 5'd12, 6'd2, 64'hBBBB, 1'b0);
    finish_cmd("held_b");

    // Reset sampled at the edge that would start the 3rd FILL write.
    saved22 = rf[22];
    start_cmd(2'd1, 5'd0, 5'd20, 6'd8, 64'hC0FFEE, 1'b0);
    tick();
    Reset = 1'b1;
    tick();
    check_reset_values("abort");
    check("abort_writes", n_writes - wr_base, 2);
    Reset    = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (Done === 1'b1) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);
    check("abort_writes_after", n_writes - wr_base, 2);
    check("abort_r20", rf[20], 64'hC0FFEE);
    check("abort_r21", rf[21], 64'hC0FFEE);
    check("abort_r22_kept", rf[22], saved22);
    mrf[20] = 64'hC0FFEE;
    mrf[21] = 64'hC0FFEE;

    // Reset wins over a command offered in the same cycle.
    base     = n_writes;
    CmdOp    = 2'd1;
    CmdDst   = 5'd2;
    CmdCount = 6'd3;
    CmdImm   = 64'h77;
    CmdValid = 1'b1;
    Reset    = 1'b1;
    tick();
    Reset    = 1'b0;
    CmdValid = 1'b0;
    check("rst_prio_ready", CmdReady, 1);
    saw_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (Done === 1'b1) saw_done = 1'b1;
    end
    check("rst_prio_no_done", saw_done, 0);
    check("rst_prio_no_writes", n_writes - base, 0);

    // Randomized commands against the reference model.
    for (int t = 0; t < 40; t++) begin
      int sel;
      r_op = 2'($urandom_range(0, 3));
      sel  = $urandom_range(0, 9);
      if (sel == 0) r_cnt = 6'd0;
      else if (sel == 1) r_cnt = 6'($urandom_range(33, 63));
      else r_cnt = 6'($urandom_range(1, 32));
      start_cmd(r_op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                r_cnt, {$urandom, $urandom}, 1'b0);
      finish_cmd($sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
